// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider (div_unit, div_step).
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } op_t;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

  // Iteration-counter width for an arbitrary operand width.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes (combinational).
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    trial   = shifted - {2'b00, dvs};
    borrow  = trial[WIDTH+1];
    rem_out = borrow ? shifted[WIDTH:0] : trial[WIDTH:0];
    quo_out = {quo_in[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider, one quotient bit per CALC cycle.
// Optional DIV_UNIT_FASTPATH_EN: divide-by-zero and signed overflow skip CALC.
//
// state | meaning
// IDLE  | waiting for start with a valid op select
// CALC  | WIDTH shift-subtract iterations, down-counter runs to zero
// FIN   | result valid, done pulses for one cycle
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             div_sel_div,
  input  logic             div_sel_divu,
  input  logic             div_sel_rem,
  input  logic             div_sel_remu,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  op_t              op_in;
  logic             sel_any, is_signed_in, is_rem_in, a_neg, b_neg;
  logic             div0_in, ovf_in, special_in, fast_in, accept;
  logic [WIDTH-1:0] a_mag, b_mag, spec_val_in, final_val;

  logic [WIDTH:0]   rem_q, rem_nxt;
  logic [WIDTH-1:0] quo_q, quo_nxt, dvs_q, spec_val_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_quo_q, neg_rem_q, is_rem_q, special_q;

  always_comb begin
    sel_any = div_sel_div | div_sel_divu | div_sel_rem | div_sel_remu;
    op_in   = DIV;
    if (div_sel_div)       op_in = DIV;
    else if (div_sel_divu) op_in = DIVU;
    else if (div_sel_rem)  op_in = REM;
    else if (div_sel_remu) op_in = REMU;
    is_signed_in = (op_in == DIV) || (op_in == REM);
    is_rem_in    = (op_in == REM) || (op_in == REMU);
    a_neg        = is_signed_in & operand_a[WIDTH-1];
    b_neg        = is_signed_in & operand_b[WIDTH-1];
    a_mag        = a_neg ? -operand_a : operand_a;
    b_mag        = b_neg ? -operand_b : operand_b;
    div0_in      = (operand_b == '0);
    ovf_in       = is_signed_in && (operand_a == {1'b1, {(WIDTH-1){1'b0}}})
                   && (operand_b == '1);
    special_in   = div0_in | ovf_in;
    spec_val_in  = is_rem_in ? (div0_in ? operand_a : '0)
                             : (div0_in ? '1 : operand_a);
    accept       = (state == IDLE) && start && sel_any && !kill;
  end

`ifdef DIV_UNIT_FASTPATH_EN
  assign fast_in = special_in;
`else
  assign fast_in = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .dvs     (dvs_q),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast_in ? FIN : CALC;
      CALC:    if (cnt_q == '0) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == FIN) && !kill;
  end

  // Special cases override the iterated value so both builds agree bit for bit.
  always_comb begin
    if (special_q)     final_val = spec_val_q;
    else if (is_rem_q) final_val = neg_rem_q ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
    else               final_val = neg_quo_q ? -quo_nxt : quo_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_rem_q   <= 1'b0;
      special_q  <= 1'b0;
      spec_val_q <= '0;
      result_q   <= '0;
    end else if (accept) begin
      rem_q      <= '0;
      quo_q      <= a_mag;
      dvs_q      <= b_mag;
      cnt_q      <= CW'(WIDTH - 1);
      neg_quo_q  <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      is_rem_q   <= is_rem_in;
      special_q  <= special_in;
      spec_val_q <= spec_val_in;
      if (fast_in) result_q <= spec_val_in;
    end else if ((state == CALC) && !kill) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) result_q <= final_val;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (WIDTH=32).
module tb_div_unit;

  localparam logic [3:0] S_DIV  = 4'b1000;
  localparam logic [3:0] S_DIVU = 4'b0100;
  localparam logic [3:0] S_REM  = 4'b0010;
  localparam logic [3:0] S_REMU = 4'b0001;
`ifdef DIV_UNIT_FASTPATH_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        div_sel_div = 1'b0, div_sel_divu = 1'b0, div_sel_rem = 1'b0, div_sel_remu = 1'b0;
  logic        kill = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .operand_a(operand_a), .operand_b(operand_b),
    .div_sel_div(div_sel_div), .div_sel_divu(div_sel_divu),
    .div_sel_rem(div_sel_rem), .div_sel_remu(div_sel_remu),
    .kill(kill), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns right after the accepting posedge.
  task automatic launch(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    {div_sel_div, div_sel_divu, div_sel_rem, div_sel_remu} = sel;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    @(posedge clk);
  endtask

  // Counts negedges after the accepting edge until done; also samples done once more.
  task automatic wait_done(output int lat, output logic [31:0] res, output logic seen, output logic dbl);
    lat = 0; seen = 1'b0; dbl = 1'b0; res = '0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done === 1'b1) begin
        seen = 1'b1;
        res = result;
      end
    end
    @(negedge clk);
    dbl = done;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
    end
    rst = 1'b0;
  endtask

  task automatic run_case(input string name, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat; logic [31:0] res; logic seen, dbl;
    launch(sel, a, b);
    wait_done(lat, res, seen, dbl);
    checks++;
    if (!seen || res !== exp) begin
      failures++;
      $display("FAIL %s result=%h seen=%b, required %h", name, res, seen, exp);
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s_latency got=%0d, required %0d", name, lat, exp_lat);
    end
    checks++;
    if (dbl !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_twice done=%b, required 0", name, dbl);
    end
  endtask

  task automatic test_unsigned();
    run_case("divu_100_7", S_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_case("remu_100_7", S_REMU, 32'd100, 32'd7, 32'd2, 33);
  endtask

  task automatic test_signed();
    run_case("rem_m7_2",   S_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_case("div_m7_2",   S_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_case("div_m100_7", S_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
    run_case("rem_100_m7", S_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 33);
  endtask

  task automatic test_div_zero();
    run_case("div_5_0",   S_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, ZLAT);
    run_case("remu_5_0",  S_REMU, 32'd5, 32'd0, 32'd5, ZLAT);
    run_case("divu_9_0",  S_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, ZLAT);
    run_case("rem_m5_0",  S_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, ZLAT);
  endtask

  task automatic test_overflow();
    run_case("div_ovf", S_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, ZLAT);
    run_case("rem_ovf", S_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, ZLAT);
  endtask

  task automatic test_noop();
    launch(4'b0000, 32'd10, 32'd2);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL noop_select busy=%b, required 0", busy);
    end
    kill = 1'b1;
    launch(S_DIVU, 32'd10, 32'd2);
    @(negedge clk);
    start = 1'b0;
    kill = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL kill_start_idle busy=%b, required 0", busy);
    end
  endtask

  task automatic test_kill();
    logic saw;
    run_case("divu_1000_10", S_DIVU, 32'd1000, 32'd10, 32'd100, 33);
    launch(S_DIVU, 32'd77, 32'd7);
    saw = 1'b0;
    for (int lat = 1; lat <= 11; lat++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) saw = 1'b1;
      if (lat == 10) kill = 1'b1;
      if (lat == 11) begin
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL kill_busy busy=%b, required 0", busy);
        end
      end
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      failures++;
      $display("FAIL kill_no_done saw_done=%b, required 0", saw);
    end
    checks++;
    if (result !== 32'd100) begin
      failures++;
      $display("FAIL kill_result result=%h, required %h", result, 32'd100);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res; logic seen;
    launch(S_DIVU, 32'd100, 32'd7);
    lat = 0; seen = 1'b0; res = '0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      start = (lat == 5);
      if (lat == 5) begin
        {div_sel_div, div_sel_divu, div_sel_rem, div_sel_remu} = S_REMU;
        operand_a = 32'd9;
        operand_b = 32'd2;
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        res = result;
      end
    end
    checks++;
    if (!seen || res !== 32'd14 || lat != 33) begin
      failures++;
      $display("FAIL b2b_first result=%h lat=%0d, required 0000000e at 33", res, lat);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_queue busy=%b, required 0", busy);
    end
  endtask

  task automatic test_rst_mid();
    int lat; logic [31:0] res; logic seen, dbl;
    launch(S_DIVU, 32'd1000, 32'd10);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
    end
    @(negedge clk);
    rst = 1'b0;
    launch(S_DIVU, 32'd9, 32'd3);
    wait_done(lat, res, seen, dbl);
    checks++;
    if (!seen || res !== 32'd3 || lat != 33) begin
      failures++;
      $display("FAIL rst_recover result=%h lat=%0d, required 00000003 at 33", res, lat);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_noop();
    test_kill();
    test_back_to_back();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
